carry_lookahead_adder_controller: RTL and testbench

//  Control side of the carry-lookahead adder datapath: takes operands one word
//  at a time over a valid/ready stream and drives the datapath's load/clear

---
 rtl/carry_lookahead_adder_controller.sv | 132 +++++++++++++
 tb/tb_carry_lookahead_adder_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/carry_lookahead_adder_controller.sv
// Controller for the carry-lookahead adder datapath. It accepts A then B over a valid/ready
// stream, strobes the datapath registers, waits for the adder to settle and holds the {carry, sum} result.
module carry_lookahead_adder_controller #(
  parameter int N             = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_data_i,
  input  logic         in_cin_i,
  output logic         dp_load_a_o,
  output logic         dp_load_b_o,
  output logic         dp_clr_a_o,
  output logic         dp_clr_b_o,
  output logic         dp_carry_in_o,
  output logic [N-1:0] dp_data_in_o,
  input  logic [N:0]   dp_data_out_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [N:0]   res_data_o,
  output logic         busy_o
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    CLEAR,
    WAIT_A,
    WAIT_B,
    SETTLE,
    RESULT
  } state_e;

  state_e         state_q, state_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           res_valid_q, res_valid_d;
  logic [N:0]     res_data_q, res_data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CLEAR;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    in_ready_o  = 1'b0;
    dp_load_a_o = 1'b0;
    dp_load_b_o = 1'b0;
    dp_clr_a_o  = 1'b0;
    dp_clr_b_o  = 1'b0;
    busy_o      = 1'b1;

    case (state_q)
      CLEAR: begin
        dp_clr_a_o = 1'b1;
        dp_clr_b_o = 1'b1;
        state_d    = WAIT_A;
      end
      WAIT_A: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) begin
          dp_load_a_o = 1'b1;
          state_d     = WAIT_B;
        end
      end
      WAIT_B: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          dp_load_b_o = 1'b1;
          carry_d     = in_cin_i;
          cnt_d       = CW'(SETTLE_CYCLES);
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        // The last settle cycle captures the adder output at its closing edge
        if (cnt_q == CW'(1)) begin
          res_data_d  = dp_data_out_i;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready_i) begin
          dp_clr_a_o  = 1'b1;
          dp_clr_b_o  = 1'b1;
          res_valid_d = 1'b0;
          state_d     = WAIT_A;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // Reset forces the datapath clear right away and blocks loads in the same cycle
    if (rst_i) begin
      in_ready_o  = 1'b0;
      dp_load_a_o = 1'b0;
      dp_load_b_o = 1'b0;
      dp_clr_a_o  = 1'b1;
      dp_clr_b_o  = 1'b1;
      busy_o      = 1'b1;
    end
  end

  assign dp_data_in_o  = in_data_i;
  assign dp_carry_in_o = carry_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;

endmodule

// File: tb/tb_carry_lookahead_adder_controller.sv
// Testbench: two controllers (settle 1 and settle 3), each wired to a behavioural datapath,
// checked against plain A+B+cin arithmetic with directed and randomized operations.
module tb_carry_lookahead_adder_controller;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, inValid, inCin, resReady, sel;
  logic [N-1:0] inData;

  logic         inReady0, loadA0, loadB0, clrA0, clrB0, carry0, resValid0, busy0;
  logic [N-1:0] dpIn0;
  logic [N:0]   dpOut0, resData0;
  logic         inReady1, loadA1, loadB1, clrA1, clrB1, carry1, resValid1, busy1;
  logic [N-1:0] dpIn1;
  logic [N:0]   dpOut1, resData1;

  carry_lookahead_adder_controller #(.N(N), .SETTLE_CYCLES(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid & ~sel), .in_ready_o(inReady0),
    .in_data_i(inData), .in_cin_i(inCin), .dp_load_a_o(loadA0), .dp_load_b_o(loadB0),
    .dp_clr_a_o(clrA0), .dp_clr_b_o(clrB0), .dp_carry_in_o(carry0), .dp_data_in_o(dpIn0),
    .dp_data_out_i(dpOut0), .res_valid_o(resValid0), .res_ready_i(resReady & ~sel),
    .res_data_o(resData0), .busy_o(busy0));

  carry_lookahead_adder_controller #(.N(N), .SETTLE_CYCLES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid & sel), .in_ready_o(inReady1),
    .in_data_i(inData), .in_cin_i(inCin), .dp_load_a_o(loadA1), .dp_load_b_o(loadB1),
    .dp_clr_a_o(clrA1), .dp_clr_b_o(clrB1), .dp_carry_in_o(carry1), .dp_data_in_o(dpIn1),
    .dp_data_out_i(dpOut1), .res_valid_o(resValid1), .res_ready_i(resReady & sel),
    .res_data_o(resData1), .busy_o(busy1));

  // Behavioural datapaths: operand registers with clear/load and a plain adder
  logic [N-1:0] regA0 = '0, regB0 = '0, regA1 = '0, regB1 = '0;
  always @(posedge clk) begin
    if (clrA0) regA0 <= '0; else if (loadA0) regA0 <= dpIn0;
    if (clrB0) regB0 <= '0; else if (loadB0) regB0 <= dpIn0;
    if (clrA1) regA1 <= '0; else if (loadA1) regA1 <= dpIn1;
    if (clrB1) regB1 <= '0; else if (loadB1) regB1 <= dpIn1;
  end
  assign dpOut0 = {1'b0, regA0} + {1'b0, regB0} + {{N{1'b0}}, carry0};
  assign dpOut1 = {1'b0, regA1} + {1'b0, regB1} + {{N{1'b0}}, carry1};

  // Observed view of whichever controller is selected
  logic inReady, loadA, loadB, clrA, clrB, carryIn, resValid, busy;
  logic [N-1:0] dpIn;
  logic [N:0] resData;
  assign inReady  = sel ? inReady1  : inReady0;
  assign loadA    = sel ? loadA1    : loadA0;
  assign loadB    = sel ? loadB1    : loadB0;
  assign clrA     = sel ? clrA1     : clrA0;
  assign clrB     = sel ? clrB1     : clrB0;
  assign carryIn  = sel ? carry1    : carry0;
  assign resValid = sel ? resValid1 : resValid0;
  assign busy     = sel ? busy1     : busy0;
  assign dpIn     = sel ? dpIn1     : dpIn0;
  assign resData  = sel ? resData1  : resData0;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full operation on the selected controller, called at a negedge
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                               input int idle, input int hold);
    int settle;
    int waited;
    logic [N:0] expSum;
    settle = sel ? 3 : 1;
    expSum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    waited = 0;
    inValid = 1'b0;
    resReady = 1'b0;
    #1;
    while (!inReady && waited < 50) begin
      tick();
      #1;
      waited++;
    end
    checkOutput("ready for A", {31'b0, inReady}, 32'd1);

    inValid = 1'b1;
    inData  = a;
    inCin   = ~cin;
    #1;
    checkOutput("load A strobe", {30'b0, loadA, loadB}, 32'b10);
    checkOutput("bus A", {16'b0, dpIn}, {16'b0, a});
    checkOutput("idle busy", {31'b0, busy}, 32'd0);
    tick();

    repeat (idle) begin
      inValid = 1'b0;
      inData  = N'($urandom);
      #1;
      checkOutput("wait B strobes", {29'b0, inReady, loadA, loadB}, 32'b100);
      tick();
    end

    inValid = 1'b1;
    inData  = b;
    inCin   = cin;
    #1;
    checkOutput("load B strobe", {30'b0, loadA, loadB}, 32'b01);
    tick();
    inValid = 1'b0;

    for (int k = 0; k < settle; k++) begin
      #1;
      checkOutput("settle no result", {30'b0, resValid, inReady}, 32'b00);
      tick();
    end
    #1;
    checkOutput("result valid", {31'b0, resValid}, 32'd1);
    checkOutput("result data", {15'b0, resData}, {15'b0, expSum});

    repeat (hold) begin
      inValid = 1'b1;
      inData  = N'($urandom);
      #1;
      checkOutput("hold outputs", {27'b0, resValid, inReady, loadA, loadB, carryIn}, {27'b0, 4'b1000, cin});
      checkOutput("hold data", {15'b0, resData}, {15'b0, expSum});
      tick();
    end

    inValid  = 1'b0;
    resReady = 1'b1;
    #1;
    checkOutput("accept clr pulse", {30'b0, clrA, clrB}, 32'b11);
    tick();
    resReady = 1'b0;
    #1;
    checkOutput("back to wait A", {28'b0, resValid, inReady, busy, clrA}, 32'b0100);
    checkOutput("data kept", {15'b0, resData}, {15'b0, expSum});
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inCin = 1'b0; resReady = 1'b0; sel = 1'b0; inData = '0;
    @(negedge clk);
    #1;
    checkOutput("reset strobes", {27'b0, clrA, clrB, loadA, loadB, inReady}, 32'b11000);
    checkOutput("reset busy", {31'b0, busy}, 32'd1);
    tick();
    #1;
    checkOutput("reset result", {14'b0, resValid, resData}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("clear state", {29'b0, clrA, clrB, inReady}, 32'b110);
    tick();
    #1;
    checkOutput("wait A after clear", {28'b0, inReady, busy, clrA, clrB}, 32'b1000);

    $display("[TB] directed operations");
    applyStimulus(16'h1234, 16'h4321, 1'b0, 0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0, 0);
    applyStimulus(16'hA5A5, 16'h0F0F, 1'b0, 0, 5);
    applyStimulus(16'h00FF, 16'h0F0F, 1'b1, 3, 0);

    $display("[TB] reset during settle");
    inValid = 1'b1; inData = 16'h0005; inCin = 1'b0;
    tick();
    inData = 16'h0006;
    tick();
    inValid = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("mid reset strobes", {27'b0, clrA, clrB, loadA, loadB, inReady}, 32'b11000);
    tick();
    #1;
    checkOutput("mid reset result", {14'b0, resValid, resData}, 32'd0);
    rst = 1'b0;
    inValid = 1'b0;
    #1;
    checkOutput("mid reset clear", {28'b0, clrA, clrB, inReady, busy}, 32'b1101);
    tick();
    applyStimulus(16'h0001, 16'h0002, 1'b0, 0, 0);

    $display("[TB] settle of three");
    sel = 1'b1;
    applyStimulus(16'h8000, 16'h8000, 1'b1, 0, 2);

    $display("[TB] randomized operations");
    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom);
      applyStimulus(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end
endmodule
